// File: rtl/spi_master_pkg.sv
// Shared SPI master definitions: watermark event mode encoding and decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package spi_master_pkg;

  // Watermark event selection.
  // Bit 0 enables upward crossings and bit 1 enables downward crossings.
  typedef enum logic [1:0] {
    WM_OFF  = 2'b00,
    WM_UP   = 2'b01,
    WM_DOWN = 2'b10,
    WM_BOTH = 2'b11
  } wm_mode_e;

  function automatic logic wm_up_en(wm_mode_e mode);
    return (mode == WM_UP) || (mode == WM_BOTH);
  endfunction

  function automatic logic wm_down_en(wm_mode_e mode);
    return (mode == WM_DOWN) || (mode == WM_BOTH);
  endfunction

endpackage

// File: rtl/spi_master_wm_fifo.sv
// SPI master TX/RX buffer FIFO with programmable watermark event,
// full/empty status, and sticky overflow/underflow flags.
// Latency: a push appears on data_o 1 cycle later (no fall-through).
// Backpressure: ready_o drops when full. When full, a push and a pop in the
// same cycle accept only the pop.
// Ports:
//   clk_i, rst_i (async, active-high), clr_i (sync soft clear)
//   valid_i/data_i/ready_o  push side
//   valid_o/data_o/ready_i  pop side
//   elements_o, full_o, empty_o  occupancy status
//   wm_level_i, wm_mode_i -> wm_event_o  watermark crossing pulse
//   ovf_o, udf_o  sticky error flags
module spi_master_wm_fifo
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 8,
  parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        valid_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic                        ready_o,
  output logic                        valid_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  input  logic                        ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  output logic                        full_o,
  output logic                        empty_o,
  input  logic [LOG_BUFFER_DEPTH:0]   wm_level_i,
  input  logic [1:0]                  wm_mode_i,
  output logic                        wm_event_o,
  output logic                        ovf_o,
  output logic                        udf_o
);

  localparam logic [LOG_BUFFER_DEPTH:0]   DEPTH_CNT = (LOG_BUFFER_DEPTH+1)'(BUFFER_DEPTH);
  localparam logic [LOG_BUFFER_DEPTH-1:0] PTR_MAX   = LOG_BUFFER_DEPTH'(BUFFER_DEPTH-1);

  logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
  logic [LOG_BUFFER_DEPTH:0]   count;
  logic [LOG_BUFFER_DEPTH:0]   count_nxt;
  logic                        full;
  logic                        empty;
  logic                        push_acc;
  logic                        pop_acc;
  logic                        wm_hit;
  logic                        wm_event;
  logic                        ovf;
  logic                        udf;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  // Gating the push on !full is what drops the push in a full push+pop cycle.
  assign push_acc = valid_i && !full;
  assign pop_acc  = ready_i && !empty;

  always_comb begin
    count_nxt = count;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Crossing detection compares the pre- and post-update occupancy. Levels of
  // 0 or above the depth can never be crossed meaningfully, so they are masked.
  always_comb begin
    logic     lvl_ok;
    logic     up_x;
    logic     down_x;
    wm_mode_e mode;
    mode   = wm_mode_e'(wm_mode_i);
    lvl_ok = (wm_level_i != '0) && (wm_level_i <= DEPTH_CNT);
    up_x   = (count < wm_level_i) && (count_nxt >= wm_level_i);
    down_x = (count >= wm_level_i) && (count_nxt < wm_level_i);
    wm_hit = lvl_ok && ((up_x && wm_up_en(mode)) || (down_x && wm_down_en(mode)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wm_event <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (clr_i) begin
      // Clear wins over any push or pop and never raises a watermark event.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wm_event <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      end
      count    <= count_nxt;
      wm_event <= wm_hit;
      ovf      <= ovf || (valid_i && full);
      udf      <= udf || (ready_i && empty);
    end
  end

  // Storage is reset so data_o never carries X, even before the first push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (!clr_i && push_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  assign ready_o    = !full;
  assign valid_o    = !empty;
  assign data_o     = mem[rd_ptr];
  assign elements_o = count;
  assign full_o     = full;
  assign empty_o    = empty;
  assign wm_event_o = wm_event;
  assign ovf_o      = ovf;
  assign udf_o      = udf;

endmodule

// File: tb/tb_spi_master_wm_fifo.sv
// Directed bench for spi_master_wm_fifo (DATA_WIDTH=32, BUFFER_DEPTH=8).
// Inputs change 1 time unit after the rising edge. Outputs are sampled there.
module tb_spi_master_wm_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clr_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ready_i;
  logic [3:0]  elements_o;
  logic        full_o;
  logic        empty_o;
  logic [3:0]  wm_level_i;
  logic [1:0]  wm_mode_i;
  logic        wm_event_o;
  logic        ovf_o;
  logic        udf_o;

  int errors = 0;
  int checks = 0;

  spi_master_wm_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .elements_o(elements_o), .full_o(full_o), .empty_o(empty_o),
    .wm_level_i(wm_level_i), .wm_mode_i(wm_mode_i), .wm_event_o(wm_event_o),
    .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    valid_i = 1'b1; data_i = d; ready_i = 1'b0;
    step();
    valid_i = 1'b0;
  endtask

  // Checks the head word, then pops it.
  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk(tag, data_o, exp);
    ready_i = 1'b1; valid_i = 1'b0;
    step();
    ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    wm_level_i = 4'd0; wm_mode_i = 2'b00;
    step(); step();
    rst_i = 1'b0;
    step();

    // Reset state
    chk("rst_elements", 32'(elements_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_wm_event", 32'(wm_event_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_udf", 32'(udf_o), 32'd0);
    chk("rst_data", data_o, 32'd0);

    // Fill, overflow, drain in order, underflow, sticky flags, clear
    for (int i = 0; i < 8; i++) begin
      push(32'(i));
      chk("fill_elements", 32'(elements_o), 32'(i + 1));
      chk("fill_head", data_o, 32'd0);
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_ready", 32'(ready_o), 32'd0);
    push(32'h99);
    chk("hold_elements", 32'(elements_o), 32'd8);
    chk("hold_ovf", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pop_chk("drain_order", 32'(i));
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    chk("drain_udf_before", 32'(udf_o), 32'd0);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("udf_set", 32'(udf_o), 32'd1);
    chk("udf_elements", 32'(elements_o), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("ovf_sticky", 32'(ovf_o), 32'd1);
    chk("udf_sticky", 32'(udf_o), 32'd1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("clr_ovf", 32'(ovf_o), 32'd0);
    chk("clr_udf", 32'(udf_o), 32'd0);

    // Watermark up, level 5: single pulse when elements reaches 5
    wm_level_i = 4'd5; wm_mode_i = 2'b01;
    for (int i = 0; i < 6; i++) begin
      push(32'h10 + 32'(i));
      chk("wmup_event", 32'(wm_event_o), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      pop_chk("wmup_data", 32'h10 + 32'(i));
      chk("wmup_no_down", 32'(wm_event_o), 32'd0);
    end

    // Watermark both, level 5: pulse at 4->5 and at 5->4
    wm_mode_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      push(32'h50 + 32'(i));
      chk("wmboth_up", 32'(wm_event_o), (i == 4) ? 32'd1 : 32'd0);
    end
    pop_chk("wmboth_data", 32'h50);
    chk("wmboth_down", 32'(wm_event_o), 32'd1);
    chk("wmboth_elements", 32'(elements_o), 32'd4);
    step();
    chk("wmboth_one_cycle", 32'(wm_event_o), 32'd0);
    for (int i = 1; i < 5; i++) begin
      pop_chk("wmboth_rest", 32'h50 + 32'(i));
      chk("wmboth_rest_ev", 32'(wm_event_o), 32'd0);
    end

    // Level 0: never fires
    wm_level_i = 4'd0;
    push(32'h60);
    chk("wm0_push", 32'(wm_event_o), 32'd0);
    pop_chk("wm0_data", 32'h60);
    chk("wm0_pop", 32'(wm_event_o), 32'd0);

    // Level 9: never fires, even filling to 8
    wm_level_i = 4'd9;
    for (int i = 0; i < 8; i++) begin
      push(32'h20 + 32'(i));
      chk("wm9_event", 32'(wm_event_o), 32'd0);
    end

    // Push and pop together at full: only the pop is taken
    chk("full_head", data_o, 32'h20);
    valid_i = 1'b1; data_i = 32'hAA; ready_i = 1'b1;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    chk("full_pp_elements", 32'(elements_o), 32'd7);
    chk("full_pp_ready", 32'(ready_o), 32'd1);
    chk("full_pp_ovf", 32'(ovf_o), 32'd1);
    for (int i = 1; i < 8; i++) begin
      pop_chk("full_pp_drop", 32'h20 + 32'(i));
    end
    chk("full_pp_empty", 32'(empty_o), 32'd1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;

    // Push and pop together at 3: count stays, order preserved
    wm_level_i = 4'd0; wm_mode_i = 2'b00;
    push(32'h30); push(32'h31); push(32'h32);
    valid_i = 1'b1; data_i = 32'h33; ready_i = 1'b1;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    chk("mid_pp_elements", 32'(elements_o), 32'd3);
    pop_chk("mid_pp_order", 32'h31);
    pop_chk("mid_pp_order", 32'h32);
    pop_chk("mid_pp_order", 32'h33);

    // Clear at 6 elements with push/pop pending: empty, no watermark event
    wm_level_i = 4'd5; wm_mode_i = 2'b11;
    for (int i = 0; i < 6; i++) push(32'h70 + 32'(i));
    chk("clr6_pre_elements", 32'(elements_o), 32'd6);
    clr_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'h77;
    step();
    clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    chk("clr6_elements", 32'(elements_o), 32'd0);
    chk("clr6_wm_event", 32'(wm_event_o), 32'd0);
    chk("clr6_empty", 32'(empty_o), 32'd1);

    // Pointer wrap at steady occupancy 3
    wm_level_i = 4'd0; wm_mode_i = 2'b00;
    push(32'h40); push(32'h41); push(32'h42);
    for (int i = 0; i < 20; i++) begin
      chk("wrap_head", data_o, 32'h40 + 32'(i));
      valid_i = 1'b1; data_i = 32'h43 + 32'(i); ready_i = 1'b1;
      step();
      valid_i = 1'b0; ready_i = 1'b0;
      chk("wrap_elements", 32'(elements_o), 32'd3);
    end
    pop_chk("wrap_tail", 32'h54);
    pop_chk("wrap_tail", 32'h55);
    pop_chk("wrap_tail", 32'h56);

    // Async reset between edges at 4 elements
    for (int i = 0; i < 4; i++) push(32'h80 + 32'(i));
    chk("arst_pre_elements", 32'(elements_o), 32'd4);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_elements", 32'(elements_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_empty", 32'(empty_o), 32'd1);
    #1 rst_i = 1'b0;
    step();
    chk("arst_after_elements", 32'(elements_o), 32'd0);
    chk("arst_after_data", data_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
